// File: rtl/nibble_serial_add_seq_if.sv
// Operation handshake between a requester and the nibble-serial adder.
// The requester (master) drives start/operands; the adder (slave) returns
// status and the registered result.
interface nibble_serial_add_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/nibble_serial_add_seq.sv
// Multi-cycle WIDTH-bit adder: drives an external combinational 4-bit slice
// one nibble per clock, LS nibble first, and gathers the slice results into
// a registered sum/cout. One slice serves any WIDTH (multiple of 4).
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_add_seq_if.slave op_if,
  output logic [3:0]             slice_a_o,
  output logic [3:0]             slice_b_o,
  output logic                   slice_cin_o,
  input  logic [3:0]             slice_sum_i,
  input  logic                   slice_cout_i
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state: accept in IDLE, step one nibble per cycle in RUN, pulse DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (op_if.start) begin
          a_d     = op_if.a;
          b_d     = op_if.b;
          carry_d = op_if.cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_sum_i;
        carry_d                    = slice_cout_i;
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_cout_i;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    // Status flags are registered copies of the upcoming state.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Slice feed: current operand nibbles and running carry, zero outside RUN.
  always_comb begin
    slice_a_o   = 4'h0;
    slice_b_o   = 4'h0;
    slice_cin_o = 1'b0;
    if (state_q == S_RUN) begin
      slice_a_o   = a_q[{idx_q, 2'b00} +: 4];
      slice_b_o   = b_q[{idx_q, 2'b00} +: 4];
      slice_cin_o = carry_q;
    end else begin
      slice_a_o   = 4'h0;
      slice_b_o   = 4'h0;
      slice_cin_o = 1'b0;
    end
  end

  // State, datapath and status registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign op_if.busy = busy_q;
  assign op_if.done = done_q;
  assign op_if.sum  = sum_q;
  assign op_if.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq at WIDTH 16, 4 and 32.
// Each DUT gets a behavioural 4-bit slice; results are compared with plain
// a + b + cin arithmetic.
module tb_nibble_serial_add_seq;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_seq_if #(.WIDTH(16)) if16 ();
  nibble_serial_add_seq_if #(.WIDTH(4))  if4  ();
  nibble_serial_add_seq_if #(.WIDTH(32)) if32 ();

  logic [3:0] sa0, sb0, ss0, sa1, sb1, ss1, sa2, sb2, ss2;
  logic       sci0, sc0, sci1, sc1, sci2, sc2;

  nibble_serial_add_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .op_if(if16.slave),
    .slice_a_o(sa0), .slice_b_o(sb0), .slice_cin_o(sci0),
    .slice_sum_i(ss0), .slice_cout_i(sc0));
  nibble_serial_add_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .op_if(if4.slave),
    .slice_a_o(sa1), .slice_b_o(sb1), .slice_cin_o(sci1),
    .slice_sum_i(ss1), .slice_cout_i(sc1));
  nibble_serial_add_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .op_if(if32.slave),
    .slice_a_o(sa2), .slice_b_o(sb2), .slice_cin_o(sci2),
    .slice_sum_i(ss2), .slice_cout_i(sc2));

  // Behavioural combinational 4-bit slices.
  assign {sc0, ss0} = 5'(sa0) + 5'(sb0) + 5'(sci0);
  assign {sc1, ss1} = 5'(sa1) + 5'(sb1) + 5'(sci1);
  assign {sc2, ss2} = 5'(sa2) + 5'(sb2) + 5'(sci2);

  logic [31:0] sum_v [3];
  logic        cout_v [3];
  logic        busy_v [3];
  logic        done_v [3];

  assign sum_v[0]  = {16'h0000, if16.sum};
  assign sum_v[1]  = {28'h0000000, if4.sum};
  assign sum_v[2]  = if32.sum;
  assign cout_v[0] = if16.cout;
  assign cout_v[1] = if4.cout;
  assign cout_v[2] = if32.cout;
  assign busy_v[0] = if16.busy;
  assign busy_v[1] = if4.busy;
  assign busy_v[2] = if32.busy;
  assign done_v[0] = if16.done;
  assign done_v[1] = if4.done;
  assign done_v[2] = if32.done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    case (sel)
      0: begin if16.start = st; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = c; end
      1: begin if4.start  = st; if4.a  = a[3:0];  if4.b  = b[3:0];  if4.cin  = c; end
      default: begin if32.start = st; if32.a = a; if32.b = b; if32.cin = c; end
    endcase
  endtask

  // One complete operation: pulse start, check latency, busy length, result.
  task automatic run_op(input int sel, input int w, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input string tag);
    logic [31:0] mask;
    logic [32:0] exp;
    int cyc;
    int busy_n;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    exp  = 33'(a & mask) + 33'(b & mask) + 33'(c);
    @(negedge clk);
    drive(sel, 1'b1, a, b, c);
    @(negedge clk);
    drive(sel, 1'b0, $urandom, $urandom, 1'($urandom));
    cyc    = 1;
    busy_n = 0;
    while (!done_v[sel] && cyc <= w / 4 + 4) begin
      if (busy_v[sel]) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(w / 4 + 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(w / 4));
    check({tag, "_sum"}, 64'(sum_v[sel]), 64'(exp[31:0] & mask));
    check({tag, "_cout"}, 64'(cout_v[sel]), 64'(exp[w]));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done_v[sel]), 64'd0);
  endtask

  initial begin
    int dn_cnt;
    logic [31:0] ra, rb;
    logic        rc;
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(2, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_sum", 64'(if16.sum), 64'd0);
    check("rst_cout", 64'(if16.cout), 64'd0);
    check("rst_busy", 64'(if16.busy), 64'd0);
    check("rst_done", 64'(if16.done), 64'd0);
    check("rst_slice", 64'({sa0, sb0, sci0}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 16-bit cases.
    run_op(0, 16, 32'h1234, 32'h4321, 1'b0, "add_5555");
    run_op(0, 16, 32'hFFFF, 32'h0001, 1'b0, "ripple_b1");
    run_op(0, 16, 32'hFFFF, 32'h0000, 1'b1, "ripple_cin");
    run_op(0, 16, 32'h8000, 32'h8000, 1'b1, "top_carry");
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b0, $urandom, $urandom, 1'($urandom));
      @(negedge clk);
      check("hold_sum", 64'(if16.sum), 64'h0001);
      check("hold_cout", 64'(if16.cout), 64'd1);
    end

    // Start re-pulsed during RUN must be ignored.
    drive(0, 1'b1, 32'h0F0F, 32'h00F1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 32'hAAAA, 32'h5555, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (if16.done) dn_cnt++;
      @(negedge clk);
    end
    check("ignore_done_count", 64'(dn_cnt), 64'd1);
    check("ignore_sum", 64'(if16.sum), 64'h1000);
    check("ignore_cout", 64'(if16.cout), 64'd0);

    // Asynchronous reset two cycles into RUN.
    drive(0, 1'b1, 32'h1234, 32'h1111, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(if16.sum), 64'd0);
    check("abort_cout", 64'(if16.cout), 64'd0);
    check("abort_busy", 64'(if16.busy), 64'd0);
    check("abort_slice_a", 64'(sa0), 64'd0);
    dn_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (if16.done) dn_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if16.done || if16.busy) dn_cnt++;
    end
    check("abort_no_done", 64'(dn_cnt), 64'd0);
    run_op(0, 16, 32'h0001, 32'h0001, 1'b0, "after_reset");

    // WIDTH=4: single RUN cycle.
    run_op(1, 4, 32'h9, 32'h8, 1'b1, "w4_9p8p1");

    // Random WIDTH=32 run.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      if (i == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1'b1; end
      run_op(2, 32, ra, rb, rc, "w32_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
